// File: rtl/dma_addr_gen_mc_if.sv
// Microsequencer-side bus of the multi-channel DMA address generator.
interface dma_addr_gen_mc_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 2,
   parameter int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1
);
   logic [2:0]       instr;
   logic [CHW-1:0]   ch_sel;
   logic [WIDTH-1:0] datain;
   logic [WIDTH-1:0] dataout;
   logic             oedata;
   logic             cina;
   logic             cinw;
   logic [WIDTH-1:0] address;
   logic             cona;
   logic             conw;
   logic             done;
   logic [NCH-1:0]   done_vec;

   // Sequencer drives instructions and count enables
   modport master (
      output instr, ch_sel, datain, cina, cinw,
      input  dataout, oedata, address, cona, conw, done, done_vec
   );

   // Address generator responds
   modport slave (
      input  instr, ch_sel, datain, cina, cinw,
      output dataout, oedata, address, cona, conw, done, done_vec
   );
endinterface

// File: rtl/dma_addr_gen_mc.sv
// Multi-channel am2940-style DMA address / word-count generator with
// per-channel done flags, count inhibit at done and optional auto-reload.
module dma_addr_gen_mc #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 2,
   parameter int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   dma_addr_gen_mc_if.slave    bus
);

   localparam logic [2:0] I_WRCR   = 3'd0;
   localparam logic [2:0] I_RDCR   = 3'd1;
   localparam logic [2:0] I_RDWC   = 3'd2;
   localparam logic [2:0] I_RDAC   = 3'd3;
   localparam logic [2:0] I_REINIT = 3'd4;
   localparam logic [2:0] I_LDAD   = 3'd5;
   localparam logic [2:0] I_LDWC   = 3'd6;
   localparam logic [2:0] I_ENCT   = 3'd7;

   logic [3:0]       cr_q [NCH];
   logic [3:0]       cr_d [NCH];
   logic [WIDTH-1:0] ar_q [NCH];
   logic [WIDTH-1:0] ar_d [NCH];
   logic [WIDTH-1:0] ac_q [NCH];
   logic [WIDTH-1:0] ac_d [NCH];
   logic [WIDTH-1:0] wr_q [NCH];
   logic [WIDTH-1:0] wr_d [NCH];
   logic [WIDTH-1:0] wc_q [NCH];
   logic [WIDTH-1:0] wc_d [NCH];

   logic [NCH-1:0]   done_c;
   logic             sel_valid_c;
   logic [3:0]       sel_cr_c;
   logic [WIDTH-1:0] sel_ac_c;
   logic [WIDTH-1:0] sel_wc_c;
   logic             sel_done_c;
   logic             sel_cnt_c;

   // Word counter step: mode 0 down, modes 1/3 up, mode 2 hold
   function automatic logic [WIDTH-1:0] wc_step(input logic [1:0] mode,
                                                input logic [WIDTH-1:0] wc);
      case (mode)
         2'd0:    wc_step = wc - WIDTH'(1);
         2'd2:    wc_step = wc;
         default: wc_step = wc + WIDTH'(1);
      endcase
   endfunction

   // Done flag per channel, derived from current register contents
   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         case (cr_q[i][1:0])
            2'd0:    done_c[i] = (wc_q[i] == '0);
            2'd1:    done_c[i] = (wc_q[i] == wr_q[i]);
            2'd2:    done_c[i] = (ac_q[i] == wr_q[i]);
            default: done_c[i] = 1'b0;
         endcase
      end
   end

   // Select the addressed channel; out-of-range selects read as zero
   always_comb begin
      sel_valid_c = (32'(bus.ch_sel) < NCH);
      sel_cr_c    = '0;
      sel_ac_c    = '0;
      sel_wc_c    = '0;
      sel_done_c  = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (sel_valid_c && (bus.ch_sel == CHW'(i))) begin
            sel_cr_c   = cr_q[i];
            sel_ac_c   = ac_q[i];
            sel_wc_c   = wc_q[i];
            sel_done_c = done_c[i];
         end
      end
      sel_cnt_c = sel_valid_c && (bus.instr == I_ENCT) && !sel_done_c;
   end

   // Next-state for every channel; only the addressed one may change
   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         cr_d[i] = cr_q[i];
         ar_d[i] = ar_q[i];
         ac_d[i] = ac_q[i];
         wr_d[i] = wr_q[i];
         wc_d[i] = wc_q[i];
         if (sel_valid_c && (bus.ch_sel == CHW'(i))) begin
            case (bus.instr)
               I_WRCR: cr_d[i] = bus.datain[3:0];
               I_REINIT: begin
                  ac_d[i] = ar_q[i];
                  wc_d[i] = (cr_q[i][1:0] == 2'd0) ? wr_q[i] : '0;
               end
               I_LDAD: begin
                  ar_d[i] = bus.datain;
                  ac_d[i] = bus.datain;
               end
               I_LDWC: begin
                  wr_d[i] = bus.datain;
                  wc_d[i] = (cr_q[i][1:0] == 2'd0) ? bus.datain : '0;
               end
               I_ENCT: begin
                  if (!done_c[i]) begin
                     if (bus.cina) begin
                        ac_d[i] = cr_q[i][2] ? ac_q[i] - WIDTH'(1)
                                             : ac_q[i] + WIDTH'(1);
                     end
                     if (bus.cinw) begin
                        wc_d[i] = wc_step(cr_q[i][1:0], wc_q[i]);
                     end
                  end else if (cr_q[i][3] && (bus.cina || bus.cinw)) begin
                     ac_d[i] = ar_q[i];
                     wc_d[i] = (cr_q[i][1:0] == 2'd0) ? wr_q[i] : '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Channel register file with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            cr_q[i] <= '0;
            ar_q[i] <= '0;
            ac_q[i] <= '0;
            wr_q[i] <= '0;
            wc_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            cr_q[i] <= cr_d[i];
            ar_q[i] <= ar_d[i];
            ac_q[i] <= ac_d[i];
            wr_q[i] <= wr_d[i];
            wc_q[i] <= wc_d[i];
         end
      end
   end

   // Combinational read path and carry outputs for the addressed channel
   always_comb begin
      bus.dataout = '0;
      bus.oedata  = 1'b0;
      if (sel_valid_c) begin
         case (bus.instr)
            I_RDCR: begin
               bus.dataout = WIDTH'(sel_cr_c);
               bus.oedata  = 1'b1;
            end
            I_RDWC: begin
               bus.dataout = sel_wc_c;
               bus.oedata  = 1'b1;
            end
            I_RDAC: begin
               bus.dataout = sel_ac_c;
               bus.oedata  = 1'b1;
            end
            default: ;
         endcase
      end
      bus.cona = sel_cnt_c && bus.cina &&
                 (sel_cr_c[2] ? (sel_ac_c == '0) : (sel_ac_c == '1));
      case (sel_cr_c[1:0])
         2'd0:    bus.conw = sel_cnt_c && bus.cinw && (sel_wc_c == '0);
         2'd2:    bus.conw = 1'b0;
         default: bus.conw = sel_cnt_c && bus.cinw && (sel_wc_c == '1);
      endcase
   end

   assign bus.address  = sel_ac_c;
   assign bus.done     = sel_done_c;
   assign bus.done_vec = done_c;

endmodule

// File: tb/tb_dma_addr_gen_mc.sv
// Directed bench for dma_addr_gen_mc (WIDTH=8, NCH=2).
module tb_dma_addr_gen_mc;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NCH   = 2;
   localparam int unsigned CHW   = 1;

   localparam int WRCR = 0, RDCR = 1, RDWC = 2, RDAC = 3;
   localparam int REINIT = 4, LDAD = 5, LDWC = 6, ENCT = 7;

   typedef struct {
      logic [2:0] ins;
      logic       ch;
      logic [7:0] din;
      logic       ca;
      logic       cw;
      logic [7:0] addr;
      logic [7:0] dout;
      logic       oe;
      logic       coa;
      logic       cow;
      logic       dn;
      logic [1:0] dv;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   vec_t vecs[$];

   dma_addr_gen_mc_if #(.WIDTH(WIDTH), .NCH(NCH), .CHW(CHW)) bus ();

   dma_addr_gen_mc #(.WIDTH(WIDTH), .NCH(NCH), .CHW(CHW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(input int ins, input int ch, input int din,
                              input int ca, input int cw, input int addr,
                              input int dout, input int oe, input int coa,
                              input int cow, input int dn, input int dv);
      vec_t t;
      t.ins = 3'(ins);  t.ch = 1'(ch);    t.din = 8'(din);
      t.ca = 1'(ca);    t.cw = 1'(cw);    t.addr = 8'(addr);
      t.dout = 8'(dout); t.oe = 1'(oe);   t.coa = 1'(coa);
      t.cow = 1'(cow);  t.dn = 1'(dn);    t.dv = 2'(dv);
      return t;
   endfunction

   task automatic drive(input int ins, input int ch, input int din,
                        input int ca, input int cw);
      bus.instr  = 3'(ins);
      bus.ch_sel = 1'(ch);
      bus.datain = 8'(din);
      bus.cina   = 1'(ca);
      bus.cinw   = 1'(cw);
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one vector after the falling edge, compare just before the rising edge
   task automatic run_vec(input vec_t t, input int idx);
      logic [21:0] act, exp;
      @(negedge clk);
      drive(int'(t.ins), int'(t.ch), int'(t.din), int'(t.ca), int'(t.cw));
      #1;
      act = {bus.address, bus.dataout, bus.oedata, bus.cona, bus.conw,
             bus.done, bus.done_vec};
      exp = {t.addr, t.dout, t.oe, t.coa, t.cow, t.dn, t.dv};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL vec%0d: got addr=%h dout=%h oe=%b cona=%b conw=%b done=%b dv=%b expected addr=%h dout=%h oe=%b cona=%b conw=%b done=%b dv=%b",
                  idx, bus.address, bus.dataout, bus.oedata, bus.cona,
                  bus.conw, bus.done, bus.done_vec, t.addr, t.dout, t.oe,
                  t.coa, t.cow, t.dn, t.dv);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //                ins    ch din  ca cw  addr  dout oe coa cow dn dv
      // mode 0 count on ch0
      vecs.push_back(v(LDAD,   0, 8'h10, 0, 0, 8'h00, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(LDWC,   0, 3,     0, 0, 8'h10, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(WRCR,   0, 0,     0, 0, 8'h10, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h10, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h11, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h12, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h13, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(RDWC,   0, 0,     0, 0, 8'h13, 0,    1, 0, 0, 1, 2'b11));
      vecs.push_back(v(RDAC,   0, 0,     0, 0, 8'h13, 8'h13,1, 0, 0, 1, 2'b11));
      // auto-reload on ch0
      vecs.push_back(v(WRCR,   0, 8'h08, 0, 0, 8'h13, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h13, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(RDWC,   0, 0,     0, 0, 8'h10, 3,    1, 0, 0, 0, 2'b10));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h10, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h11, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h12, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(RDAC,   0, 0,     0, 0, 8'h13, 8'h13,1, 0, 0, 1, 2'b11));
      // decrement with borrow on ch1
      vecs.push_back(v(WRCR,   1, 8'h07, 0, 0, 8'h00, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(LDAD,   1, 8'h00, 0, 0, 8'h00, 0,    0, 0, 0, 0, 2'b01));
      vecs.push_back(v(ENCT,   1, 0,     1, 0, 8'h00, 0,    0, 1, 0, 0, 2'b01));
      vecs.push_back(v(RDAC,   1, 0,     0, 0, 8'hFF, 8'hFF,1, 0, 0, 0, 2'b01));
      // channel isolation: ch0 mode 2, ch1 back to idle mode 0
      vecs.push_back(v(WRCR,   1, 8'h00, 0, 0, 8'hFF, 0,    0, 0, 0, 0, 2'b01));
      vecs.push_back(v(WRCR,   0, 8'h02, 0, 0, 8'h13, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(LDWC,   0, 8'h05, 0, 0, 8'h13, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(LDAD,   0, 8'h02, 0, 0, 8'h13, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h02, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h03, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h04, 0,    0, 0, 0, 0, 2'b10));
      vecs.push_back(v(RDAC,   0, 0,     0, 0, 8'h05, 8'h05,1, 0, 0, 1, 2'b11));
      vecs.push_back(v(ENCT,   0, 0,     1, 1, 8'h05, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(LDWC,   1, 8'h02, 0, 0, 8'hFF, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(RDAC,   0, 0,     0, 0, 8'h05, 8'h05,1, 0, 0, 1, 2'b01));
      vecs.push_back(v(RDWC,   1, 0,     0, 0, 8'hFF, 8'h02,1, 0, 0, 0, 2'b01));
      // mode 1 compare on ch1
      vecs.push_back(v(WRCR,   1, 8'h01, 0, 0, 8'hFF, 0,    0, 0, 0, 0, 2'b01));
      vecs.push_back(v(LDWC,   1, 8'h04, 0, 0, 8'hFF, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(ENCT,   1, 0,     0, 1, 8'hFF, 0,    0, 0, 0, 0, 2'b01));
      vecs.push_back(v(RDWC,   1, 0,     0, 0, 8'hFF, 1,    1, 0, 0, 0, 2'b01));
      vecs.push_back(v(ENCT,   1, 0,     0, 1, 8'hFF, 0,    0, 0, 0, 0, 2'b01));
      vecs.push_back(v(RDWC,   1, 0,     0, 0, 8'hFF, 2,    1, 0, 0, 0, 2'b01));
      vecs.push_back(v(ENCT,   1, 0,     0, 1, 8'hFF, 0,    0, 0, 0, 0, 2'b01));
      vecs.push_back(v(RDWC,   1, 0,     0, 0, 8'hFF, 3,    1, 0, 0, 0, 2'b01));
      vecs.push_back(v(ENCT,   1, 0,     0, 1, 8'hFF, 0,    0, 0, 0, 0, 2'b01));
      vecs.push_back(v(RDWC,   1, 0,     0, 0, 8'hFF, 4,    1, 0, 0, 1, 2'b11));
      vecs.push_back(v(REINIT, 1, 0,     0, 0, 8'hFF, 0,    0, 0, 0, 1, 2'b11));
      vecs.push_back(v(RDWC,   1, 0,     0, 0, 8'h00, 0,    1, 0, 0, 0, 2'b01));

      // Reset state with inputs idle
      rst_n = 1'b0;
      drive(WRCR, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_address", 32'(bus.address), 32'h00);
      check("rst_done_vec", 32'(bus.done_vec), 32'h3);
      check("rst_oedata", 32'(bus.oedata), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // ch1 mode 3 up-count: both counters reach all-ones after 255 steps
      @(negedge clk); drive(WRCR, 1, 8'h03, 0, 0);
      @(negedge clk); drive(LDWC, 1, 8'h00, 0, 0);
      for (int k = 0; k < 255; k++) begin
         @(negedge clk); drive(ENCT, 1, 0, 1, 1);
      end
      @(negedge clk); drive(ENCT, 1, 0, 1, 1);
      #1;
      check("wrap_address", 32'(bus.address), 32'hFF);
      check("wrap_cona", 32'(bus.cona), 32'h1);
      check("wrap_conw", 32'(bus.conw), 32'h1);
      @(negedge clk); drive(RDWC, 1, 0, 0, 0);
      #1;
      check("wrap_wc", 32'(bus.dataout), 32'h00);
      check("wrap_ac", 32'(bus.address), 32'h00);

      // Asynchronous reset in the middle of counting
      @(negedge clk); drive(ENCT, 1, 0, 1, 0);
      @(negedge clk);
      #1;
      check("precount_address", 32'(bus.address), 32'h01);
      rst_n = 1'b0;
      #1;
      check("midrst_address", 32'(bus.address), 32'h00);
      check("midrst_done_vec", 32'(bus.done_vec), 32'h3);
      check("midrst_oedata", 32'(bus.oedata), 32'h0);
      check("midrst_cona", 32'(bus.cona), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(RDCR, 1, 0, 0, 0);
      #1;
      check("post_rst_rdcr_data", 32'(bus.dataout), 32'h00);
      check("post_rst_rdcr_oe", 32'(bus.oedata), 32'h1);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
